// File: rtl/mem_access_unit.sv
// Load/store front end for d_mem: byte-address to word-index translation, byte/half RMW stores,
// lane extraction with sign/zero extension. Define MAU_ALIGN_CHECK_EN to reject misaligned half/word.
module mem_access_unit #(
  parameter int MemSize = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_done,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;
  logic        r_rsp_done;
  logic        r_rsp_error;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        w_accept;
  logic        w_illegal;
  logic [1:0]  w_lane;

  // Replace only the addressed byte/half lane of a memory word
  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] data,
                                          input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00:   res[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16] = data[15:0];
      default: res = data;
    endcase
    return res;
  endfunction

  // Right-justify the addressed lane and extend it to 32 bits
  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic uns);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign req_ready   = (r_state == S_IDLE);
  assign w_accept    = req_valid & (r_state == S_IDLE);
  assign rsp_done    = r_rsp_done;
  assign rsp_error   = r_rsp_error;
  assign rsp_rdata   = r_rsp_rdata;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;

  // Classify the incoming request and pick its effective lane
  always_comb begin
    w_illegal = (req_size == 2'b11) || (|req_addr[31:MemSize+2]);
    w_lane    = req_addr[1:0];
`ifdef MAU_ALIGN_CHECK_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
      w_illegal = 1'b1;
    end else begin
      w_illegal = w_illegal;
    end
`endif
    case (req_size)
      2'b01:   w_lane = {req_addr[1], 1'b0};
      2'b10:   w_lane = 2'b00;
      default: w_lane = req_addr[1:0];
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_next = S_IDLE;
        end else if (w_illegal) begin
          w_next = S_DONE;
        end else if (req_write && req_size == 2'b10) begin
          w_next = S_WR;
        end else begin
          w_next = S_RD;
        end
      end
      S_RD: begin
        if (r_write) begin
          w_next = S_WR;
        end else begin
          w_next = S_DONE;
        end
      end
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request capture and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_write       <= 1'b0;
      r_size        <= 2'b00;
      r_unsigned    <= 1'b0;
      r_lane        <= 2'b00;
      r_wdata       <= 32'h00000000;
      r_rsp_done    <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_rsp_rdata   <= 32'h00000000;
      r_mem_address <= 32'h00000000;
      r_mem_wdata   <= 32'h00000000;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_mem_read  <= (w_next == S_RD);
      r_mem_write <= (w_next == S_WR);
      r_rsp_done  <= (w_next == S_DONE);
      r_rsp_error <= w_accept & w_illegal;
      if (w_accept && !w_illegal) begin
        r_write       <= req_write;
        r_size        <= req_size;
        r_unsigned    <= req_unsigned;
        r_lane        <= w_lane;
        r_wdata       <= req_wdata;
        r_mem_address <= {2'b00, req_addr[31:2]};
        if (req_write && req_size == 2'b10) begin
          r_mem_wdata <= req_wdata;
        end
      end
      // mem_rdata is valid for the whole RD cycle; sample it on the way out
      if (r_state == S_RD) begin
        if (r_write) begin
          r_mem_wdata <= f_merge(mem_rdata, r_wdata, r_size, r_lane);
        end else begin
          r_rsp_rdata <= f_extract(mem_rdata, r_size, r_lane, r_unsigned);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte-array reference memory.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_done;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  mem_access_unit #(.MemSize(10)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_done(rsp_done), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // d_mem stand-in (word array) and reference model (byte array)
  logic [31:0] tb_mem [1024];
  logic [7:0]  bm [4096];
  assign mem_rdata = tb_mem[mem_address[9:0]];
  always @(posedge clock) if (mem_write) tb_mem[mem_address[9:0]] <= mem_wdata;

  typedef struct { logic err; logic [31:0] rdata; int lat; int acc; logic [31:0] widx; } exp_t;
  typedef struct { logic [31:0] widx; logic [31:0] data; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event (t=%0t)", name, $time);
  endtask

  // Monitor: compare DUT activity against queued expectations
  always @(negedge clock) begin
    if (mon_en) begin
      if (mem_read || mem_write) chk("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_read && exp_q.size() > 0) begin
        chk("rd_on_error", {31'd0, exp_q[0].err}, 32'd0);
        chk("rd_addr", mem_address, exp_q[0].widx);
      end
      if (mem_write) begin
        if (wr_q.size() == 0) flag("spurious_write");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", mem_address, w.widx);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (rsp_done) begin
        if (exp_q.size() == 0) flag("spurious_done");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("latency", 32'(cyc + 1 - e.acc), 32'(e.lat));
        end
      end
    end
  end

  // Wait for req_ready (bounded), present one request and record its expected outcome
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    int t;
    exp_t e;
    int ea, nb, w;
    logic [31:0] v;
    t = 0;
    @(negedge clock);
    while (!req_ready && t < 20) begin @(negedge clock); t++; end
    if (!req_ready) begin flag("ready_timeout"); return; end
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    e.err = (sz == 2'd3) || (a > 32'd4095);
`ifdef MAU_ALIGN_CHECK_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) e.err = 1'b1;
`endif
    e.acc = cyc + 1;
    e.widx = 32'(a[11:2]);
    if (e.err) begin
      e.lat = 1;
    end else begin
      ea = int'(a[11:0]);
      if (sz == 2'd1) ea = ea & ~1;
      if (sz == 2'd2) ea = ea & ~3;
      nb = 1 << sz;
      if (!wr) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(bm[ea + i]) << (8 * i));
        if (!uns && nb == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (!uns && nb == 2 && v[15]) v = v | 32'hFFFF0000;
        last_rdata = v;
        e.lat = 2;
      end else begin
        wr_t x;
        for (int i = 0; i < nb; i++) bm[ea + i] = wd[8 * i +: 8];
        w = ea / 4;
        x.widx = 32'(w);
        x.data = {bm[4 * w + 3], bm[4 * w + 2], bm[4 * w + 1], bm[4 * w]};
        wr_q.push_back(x);
        e.lat = (nb == 4) ? 2 : 3;
      end
    end
    e.rdata = last_rdata;
    exp_q.push_back(e);
    @(negedge clock);
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom); req_write = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_done"}, {31'd0, rsp_done}, 32'd0);
    chk({tag, "_err"}, {31'd0, rsp_error}, 32'd0);
    chk({tag, "_rd"}, {31'd0, mem_read}, 32'd0);
    chk({tag, "_wr"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_addr"}, mem_address, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 1024; i++) begin
      r = $urandom;
      tb_mem[i] <= r;
      {bm[4 * i + 3], bm[4 * i + 2], bm[4 * i + 1], bm[4 * i]} = r;
    end
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    mon_en = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80223344);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h17, 32'hCAFEBABE);
    issue(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);

    for (int n = 0; n < 300; n++) begin
      int sel;
      logic [31:0] a;
      logic [1:0] sz;
      sel = int'($urandom_range(0, 15));
      sz = (sel == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (sel == 1) a = 32'h1000 + ($urandom & 32'h0000FFFF);
      else if (sel < 9) a = 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, 4095));
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // abort a byte store while it is in RD
    begin
      int t;
      t = 0;
      while (!(req_ready && exp_q.size() == 0) && t < 50) begin @(negedge clock); t++; end
      if (!req_ready) flag("abort_ready_timeout");
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'h55;
      @(negedge clock);
      req_valid = 1'b0;
      chk("abort_in_rd", {31'd0, mem_read}, 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_wr", {31'd0, mem_write}, 32'd0);
      chk("abort_done", {31'd0, rsp_done}, 32'd0);
      reset = 1'b0;
      last_rdata = 32'h0;
      @(negedge clock);
      check_reset_outputs("abort");
      @(negedge clock);
      chk("abort_wr2", {31'd0, mem_write}, 32'd0);
      chk("abort_done2", {31'd0, rsp_done}, 32'd0);
    end

    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0);

    begin
      int t;
      t = 0;
      while ((exp_q.size() != 0 || wr_q.size() != 0) && t < 100) begin @(negedge clock); t++; end
      if (exp_q.size() != 0 || wr_q.size() != 0) flag("drain_timeout");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
